fpnew_special_encoder: RTL and testbench

//  Inverse of operand classification: builds IEEE-754 bit patterns from a value-class request and NaN-boxes them to register width.

---
 rtl/fpnew_special_encoder.sv | 196 +++++++++++++++++++
 tb/tb_fpnew_special_encoder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/fpnew_special_encoder.sv
// fpnew_special_encoder
//   Builds IEEE-754 bit patterns from a value-class request and NaN-boxes
//   them to the register width.
//   The result can be passed through NumPipeRegs stages. Each stage has a
//   valid/ready handshake, and an opaque tag travels with the data. A flush
//   input kills every request still in flight.
//
// Ports
//   clk_i        clock, rising edge
//   rst_ni       asynchronous active-low reset
//   cls_i        requested class:
//                  0 ZERO, 1 INF, 2 QNAN, 3 SNAN, 4 MAXNORM,
//                  5 MINNORM, 6 MINSUB, 7 PASS
//   sign_i       sign for the signed classes
//   operand_i    raw value returned by class PASS
//   box_i        1: upper bits padded with ones; 0: padded with zeros
//   tag_i        opaque tag, returned unchanged with the result
//   in_valid_i   request valid
//   in_ready_o   request is accepted when in_valid_i & in_ready_o
//   flush_i      drops all in-flight entries at the next edge
//   result_o     encoded, boxed value
//   tag_o        tag of result_o
//   out_valid_o  result valid
//   out_ready_i  result is consumed when out_valid_o & out_ready_i
//   busy_o       some stage holds a valid entry
module fpnew_special_encoder #(
  parameter int unsigned FpFormat    = 0,
  parameter int unsigned Width       = 64,
  parameter int unsigned NumPipeRegs = 1,
  parameter int unsigned TagWidth    = 1,
  localparam int unsigned ExpBits = (FpFormat == 1) ? 11 :
                                    (FpFormat == 2 || FpFormat == 3) ? 5 : 8,
  localparam int unsigned ManBits = (FpFormat == 0) ? 23 :
                                    (FpFormat == 1) ? 52 :
                                    (FpFormat == 2) ? 10 :
                                    (FpFormat == 3) ? 2  : 7,
  localparam int unsigned W = 1 + ExpBits + ManBits
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [2:0]          cls_i,
  input  logic                sign_i,
  input  logic [W-1:0]        operand_i,
  input  logic                box_i,
  input  logic [TagWidth-1:0] tag_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic                flush_i,
  output logic [Width-1:0]    result_o,
  output logic [TagWidth-1:0] tag_o,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic                busy_o
);

  localparam logic [2:0] ClsZero    = 3'd0;
  localparam logic [2:0] ClsInf     = 3'd1;
  localparam logic [2:0] ClsQnan    = 3'd2;
  localparam logic [2:0] ClsSnan    = 3'd3;
  localparam logic [2:0] ClsMaxNorm = 3'd4;
  localparam logic [2:0] ClsMinNorm = 3'd5;
  localparam logic [2:0] ClsMinSub  = 3'd6;

  if (Width < W) begin : g_bad_width
    $error("Width must be at least the format width");
  end
  if (NumPipeRegs > 4) begin : g_bad_depth
    $error("NumPipeRegs must be in 0..4");
  end

  function automatic logic [W-1:0] encode(input logic [2:0]   cls,
                                          input logic         sgn,
                                          input logic [W-1:0] op);
    logic               s;
    logic [ExpBits-1:0] e;
    logic [ManBits-1:0] m;
    s = sgn;
    e = '0;
    m = '0;
    case (cls)
      ClsZero: ;
      ClsInf:  e = '1;
      ClsQnan: begin
        s = 1'b0;
        e = '1;
        m[ManBits-1] = 1'b1;
      end
      ClsSnan: begin
        s = 1'b0;
        e = '1;
        m[0] = 1'b1;
      end
      ClsMaxNorm: begin
        e = '1;
        e[0] = 1'b0;
        m = '1;
      end
      ClsMinNorm: e[0] = 1'b1;
      ClsMinSub:  m[0] = 1'b1;
      default: ;
    endcase
    // PASS returns the operand untouched, sign included.
    if (cls == 3'd7) return op;
    return {s, e, m};
  endfunction

  logic [W-1:0]     enc_raw;
  logic [Width-1:0] enc_d;

  assign enc_raw = encode(cls_i, sign_i, operand_i);

  if (Width > W) begin : g_box
    assign enc_d = {{(Width - W){box_i}}, enc_raw};
  end else begin : g_nobox
    // box_i has no effect when the format already fills the register.
    logic unused_box;
    assign unused_box = box_i;
    assign enc_d      = enc_raw;
  end

  if (NumPipeRegs == 0) begin : g_comb
    // Fully combinational path; the clock, reset and flush have no effect.
    logic unused_ctrl;
    assign unused_ctrl = clk_i ^ rst_ni ^ flush_i;
    assign result_o    = enc_d;
    assign tag_o       = tag_i;
    assign out_valid_o = in_valid_i;
    assign in_ready_o  = out_ready_i;
    assign busy_o      = 1'b0;
  end else begin : g_pipe
    localparam int unsigned N = NumPipeRegs;

    logic [N-1:0]        valid_q;
    logic [Width-1:0]    data_q [N];
    logic [TagWidth-1:0] tag_q  [N];

    // Index 0 of the following arrays is the incoming request.
    // Index k+1 is the output of stage k.
    logic [N:0]          vld_s;
    logic [Width-1:0]    data_s [N+1];
    logic [TagWidth-1:0] tag_s  [N+1];
    logic [N:0]          rdy;

    assign vld_s = {valid_q, in_valid_i};

    always_comb begin
      data_s[0] = enc_d;
      tag_s[0]  = tag_i;
      for (int k = 0; k < N; k++) begin
        data_s[k+1] = data_q[k];
        tag_s[k+1]  = tag_q[k];
      end
    end

    // A stage accepts when it is empty, or when its entry moves on in the
    // same cycle. The chain is evaluated from the output back to the input.
    always_comb begin
      rdy    = '0;
      rdy[N] = out_ready_i;
      for (int k = N - 1; k >= 0; k--) begin
        rdy[k] = !valid_q[k] | rdy[k+1];
      end
    end

    // Stage registers. The data and tag registers load only on a handshake
    // into the stage, so a stalled stage keeps its contents.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q <= '0;
        for (int k = 0; k < N; k++) begin
          data_q[k] <= '0;
          tag_q[k]  <= '0;
        end
      end else begin
        for (int k = 0; k < N; k++) begin
          if (flush_i) begin
            valid_q[k] <= 1'b0;
          end else if (rdy[k]) begin
            valid_q[k] <= vld_s[k];
          end
          if (rdy[k] && vld_s[k]) begin
            data_q[k] <= data_s[k];
            tag_q[k]  <= tag_s[k];
          end
        end
      end
    end

    assign in_ready_o  = rdy[0];
    assign out_valid_o = valid_q[N-1];
    assign result_o    = data_q[N-1];
    assign tag_o       = tag_q[N-1];
    assign busy_o      = |valid_q;
  end

endmodule

// File: tb/tb_fpnew_special_encoder.sv
module tb_fpnew_special_encoder;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // a: FP32, Width 64, N=1
  logic [2:0]  a_cls = '0;
  logic        a_sign = 0, a_box = 0, a_vld = 0, a_ordy = 1, a_tag = 0;
  logic [31:0] a_op = '0;
  logic        a_irdy, a_ovld, a_busy, a_tago;
  logic [63:0] a_res;

  // b: FP16, Width 16, N=1
  logic [2:0]  b_cls = '0;
  logic        b_sign = 0, b_vld = 0, b_tag = 0;
  logic [15:0] b_op = '0;
  logic        b_irdy, b_ovld, b_busy, b_tago;
  logic [15:0] b_res;

  // c: FP32, Width 32, N=0
  logic [2:0]  c_cls = '0;
  logic        c_sign = 0, c_vld = 0, c_ordy = 1, c_tag = 0;
  logic [31:0] c_op = '0;
  logic        c_irdy, c_ovld, c_busy, c_tago;
  logic [31:0] c_res;

  // p: FP32, Width 64, N=2, 4-bit tag
  logic        p_vld = 0, p_ordy = 1, p_flush = 0;
  logic [3:0]  p_tag = '0;
  logic [31:0] p_op = '0;
  logic        p_irdy, p_ovld, p_busy;
  logic [3:0]  p_tago;
  logic [63:0] p_res;

  fpnew_special_encoder #(.FpFormat(0), .Width(64), .NumPipeRegs(1), .TagWidth(1)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .cls_i(a_cls), .sign_i(a_sign), .operand_i(a_op),
    .box_i(a_box), .tag_i(a_tag), .in_valid_i(a_vld), .in_ready_o(a_irdy),
    .flush_i(1'b0), .result_o(a_res), .tag_o(a_tago), .out_valid_o(a_ovld),
    .out_ready_i(a_ordy), .busy_o(a_busy));

  fpnew_special_encoder #(.FpFormat(2), .Width(16), .NumPipeRegs(1), .TagWidth(1)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .cls_i(b_cls), .sign_i(b_sign), .operand_i(b_op),
    .box_i(1'b1), .tag_i(b_tag), .in_valid_i(b_vld), .in_ready_o(b_irdy),
    .flush_i(1'b0), .result_o(b_res), .tag_o(b_tago), .out_valid_o(b_ovld),
    .out_ready_i(1'b1), .busy_o(b_busy));

  fpnew_special_encoder #(.FpFormat(0), .Width(32), .NumPipeRegs(0), .TagWidth(1)) dut_c (
    .clk_i(clk), .rst_ni(rst_n), .cls_i(c_cls), .sign_i(c_sign), .operand_i(c_op),
    .box_i(1'b1), .tag_i(c_tag), .in_valid_i(c_vld), .in_ready_o(c_irdy),
    .flush_i(1'b0), .result_o(c_res), .tag_o(c_tago), .out_valid_o(c_ovld),
    .out_ready_i(c_ordy), .busy_o(c_busy));

  fpnew_special_encoder #(.FpFormat(0), .Width(64), .NumPipeRegs(2), .TagWidth(4)) dut_p (
    .clk_i(clk), .rst_ni(rst_n), .cls_i(3'd7), .sign_i(1'b0), .operand_i(p_op),
    .box_i(1'b0), .tag_i(p_tag), .in_valid_i(p_vld), .in_ready_o(p_irdy),
    .flush_i(p_flush), .result_o(p_res), .tag_o(p_tago), .out_valid_o(p_ovld),
    .out_ready_i(p_ordy), .busy_o(p_busy));

  task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Directed vectors: class, sign, box, operand, expected result
  logic [2:0]  av_cls  [8] = '{3'd0, 3'd2, 3'd4, 3'd6, 3'd1, 3'd3, 3'd5, 3'd7};
  logic        av_sign [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
  logic        av_box  [8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  logic [31:0] av_op   [8] = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h3F800000};
  logic [63:0] av_exp  [8] = '{64'hFFFFFFFF_80000000, 64'hFFFFFFFF_7FC00000,
                              64'h00000000_7F7FFFFF, 64'h00000000_80000001,
                              64'hFFFFFFFF_7F800000, 64'h00000000_7F800001,
                              64'h00000000_80800000, 64'hFFFFFFFF_3F800000};
  logic [2:0]  bv_cls  [8] = '{3'd1, 3'd3, 3'd7, 3'd2, 3'd4, 3'd5, 3'd6, 3'd0};
  logic        bv_sign [8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [15:0] bv_op   [8] = '{16'h0, 16'h0, 16'h3C00, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0};
  logic [15:0] bv_exp  [8] = '{16'hFC00, 16'h7C01, 16'h3C00, 16'h7E00,
                              16'h7BFF, 16'h8400, 16'h0001, 16'h8000};

  logic        ho, hi;
  logic [3:0]  t;
  logic [63:0] d;
  logic [3:0]  gt [4];
  logic [63:0] gd [4];
  int          n;

  initial begin
    // Reset state
    #3;
    chk("rst_a_ovld", 64'(a_ovld), 64'd0);
    chk("rst_a_res",  a_res, 64'd0);
    chk("rst_a_busy", 64'(a_busy), 64'd0);
    chk("rst_a_irdy", 64'(a_irdy), 64'd1);
    chk("rst_p_irdy", 64'(p_irdy), 64'd1);
    chk("rst_p_tag",  64'(p_tago), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Class encodings, one request per cycle, N=1
    for (int i = 0; i < 8; i++) begin
      a_cls = av_cls[i]; a_sign = av_sign[i]; a_box = av_box[i]; a_op = av_op[i];
      a_tag = 1'(i); a_vld = 1'b1;
      b_cls = bv_cls[i]; b_sign = bv_sign[i]; b_op = bv_op[i];
      b_tag = 1'(i + 1); b_vld = 1'b1;
      tick();
      chk($sformatf("a_res%0d", i), a_res, av_exp[i]);
      chk($sformatf("a_ovld%0d", i), 64'(a_ovld), 64'd1);
      chk($sformatf("a_tag%0d", i), 64'(a_tago), 64'(i % 2));
      chk($sformatf("b_res%0d", i), 64'(b_res), 64'(bv_exp[i]));
    end
    a_vld = 1'b0; b_vld = 1'b0;
    tick();
    chk("a_idle_ovld", 64'(a_ovld), 64'd0);
    chk("a_idle_busy", 64'(a_busy), 64'd0);
    chk("b_idle_ovld", 64'(b_ovld), 64'd0);

    // Combinational (N=0) instance
    c_cls = 3'd1; c_sign = 1'b1; c_vld = 1'b1; c_tag = 1'b1; c_ordy = 1'b1;
    #1;
    chk("c_res_inf", 64'(c_res), 64'h0000_0000_FF80_0000);
    chk("c_ovld", 64'(c_ovld), 64'd1);
    chk("c_tag", 64'(c_tago), 64'd1);
    chk("c_irdy", 64'(c_irdy), 64'd1);
    c_ordy = 1'b0; c_cls = 3'd4;
    #1;
    chk("c_irdy_stall", 64'(c_irdy), 64'd0);
    chk("c_res_max", 64'(c_res), 64'h0000_0000_FF7F_FFFF);
    c_vld = 1'b0;
    #1;
    chk("c_ovld_off", 64'(c_ovld), 64'd0);
    chk("c_busy", 64'(c_busy), 64'd0);
    tick();

    // Backpressure, N=2: tags 1, 2, 3 back-to-back with the output stalled
    p_ordy = 1'b0;
    p_vld = 1'b1; p_tag = 4'd1; p_op = 32'h11111111;
    tick();
    p_tag = 4'd2; p_op = 32'h22222222;
    #1;
    chk("stall_irdy2", 64'(p_irdy), 64'd1);
    tick();
    p_tag = 4'd3; p_op = 32'h33333333;
    #1;
    chk("stall_irdy3", 64'(p_irdy), 64'd0);
    chk("stall_ovld", 64'(p_ovld), 64'd1);
    chk("stall_tag", 64'(p_tago), 64'd1);
    tick();
    tick();
    chk("held_tag", 64'(p_tago), 64'd1);
    chk("held_res", p_res, 64'h11111111);
    chk("held_ovld", 64'(p_ovld), 64'd1);
    chk("held_busy", 64'(p_busy), 64'd1);
    p_ordy = 1'b1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      ho = p_ovld & p_ordy;
      hi = p_vld & p_irdy;
      t = p_tago;
      d = p_res;
      tick();
      if (ho) begin
        if (n < 4) begin
          gt[n] = t;
          gd[n] = d;
        end
        n++;
      end
      if (hi) p_vld = 1'b0;
    end
    chk("drain_count", 64'(n), 64'd3);
    chk("drain_tag0", 64'(gt[0]), 64'd1);
    chk("drain_tag1", 64'(gt[1]), 64'd2);
    chk("drain_tag2", 64'(gt[2]), 64'd3);
    chk("drain_res2", gd[2], 64'h33333333);
    chk("drain_busy", 64'(p_busy), 64'd0);

    // Flush with two entries in flight and a new request in the same cycle
    p_ordy = 1'b0;
    p_vld = 1'b1; p_tag = 4'd5; p_op = 32'h55555555;
    tick();
    p_tag = 4'd6; p_op = 32'h66666666;
    tick();
    p_tag = 4'd7; p_op = 32'h77777777; p_ordy = 1'b1; p_flush = 1'b1;
    #1;
    chk("flush_pre_ovld", 64'(p_ovld), 64'd1);
    chk("flush_pre_tag", 64'(p_tago), 64'd5);
    chk("flush_irdy", 64'(p_irdy), 64'd1);
    tick();
    p_flush = 1'b0; p_vld = 1'b0;
    chk("flush_ovld", 64'(p_ovld), 64'd0);
    chk("flush_busy", 64'(p_busy), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush_after%0d", i), 64'(p_ovld), 64'd0);
    end

    // Asynchronous reset with two entries in flight
    p_ordy = 1'b0;
    p_vld = 1'b1; p_tag = 4'd8; p_op = 32'h88888888;
    tick();
    p_tag = 4'd9; p_op = 32'h99999999;
    tick();
    p_vld = 1'b0;
    chk("prerst_busy", 64'(p_busy), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_ovld", 64'(p_ovld), 64'd0);
    chk("arst_res", p_res, 64'd0);
    chk("arst_tag", 64'(p_tago), 64'd0);
    chk("arst_busy", 64'(p_busy), 64'd0);
    chk("arst_irdy", 64'(p_irdy), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    p_ordy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("postrst_ovld%0d", i), 64'(p_ovld), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
